// File: rtl/msx_bus_initiator_if.sv
// Signal bundle between a request source and the MSX slot bus cycle generator.
// master: the bus cycle generator view; slave: the requester / slot-model view.
interface msx_bus_initiator_if;
  logic        CLK_EN;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic        REQ_IO;
  logic        REQ_M1;
  logic        REQ_SLTSL;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;
  logic        RSP_ERR;
  logic [15:0] ADDR;
  logic [7:0]  DOUT;
  logic        DOUT_OE;
  logic [7:0]  DIN;
  logic        WAIT_n;
  logic        MERQ_n;
  logic        IORQ_n;
  logic        RD_n;
  logic        WR_n;
  logic        SLTSL_n;
  logic        CS1_n;
  logic        CS2_n;
  logic        CS12_n;
  logic        M1_n;
  logic        RFSH_n;

  modport master (
    input  CLK_EN, REQ_VALID, REQ_WRITE, REQ_IO, REQ_M1, REQ_SLTSL, REQ_ADDR, REQ_WDATA,
           DIN, WAIT_n,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, ADDR, DOUT, DOUT_OE,
           MERQ_n, IORQ_n, RD_n, WR_n, SLTSL_n, CS1_n, CS2_n, CS12_n, M1_n, RFSH_n
  );

  modport slave (
    output CLK_EN, REQ_VALID, REQ_WRITE, REQ_IO, REQ_M1, REQ_SLTSL, REQ_ADDR, REQ_WDATA,
           DIN, WAIT_n,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, ADDR, DOUT, DOUT_OE,
           MERQ_n, IORQ_n, RD_n, WR_n, SLTSL_n, CS1_n, CS2_n, CS12_n, M1_n, RFSH_n
  );
endinterface

// File: rtl/msx_bus_initiator.sv
// Host-side MSX slot bus cycle generator: one request becomes a Z80-style T-state
// sequenced memory/IO cycle; all bus outputs are registered from the next state.
module msx_bus_initiator #(
  parameter int IO_AUTO_WAIT  = 1,
  parameter int M1_EXTRA_WAIT = 1,
  parameter int WAIT_TIMEOUT  = 255
) (
  input  logic                CLK,
  input  logic                RESET_n,
  msx_bus_initiator_if.master bus
);
  typedef enum logic [2:0] {IDLE, ARM, T1, T2, TW, T3, DONE} state_t;

  localparam logic [7:0] IO_FORCED = 8'(IO_AUTO_WAIT);
  localparam logic [7:0] M1_FORCED = 8'(M1_EXTRA_WAIT);
  localparam logic [7:0] TMO_LIMIT = 8'(WAIT_TIMEOUT);

  state_t      state_reg, state_next;
  logic        write_reg, io_reg, m1_reg, sltsl_reg;
  logic [15:0] addr_reg;
  logic [7:0]  dout_reg, rdata_reg;
  logic [7:0]  forced_reg, forced_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic [7:0]  forced_load, wait_cnt_inc;
  logic        timeout;
  logic        err_reg, err_next;
  logic        ready_reg, ready_next;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        oe_reg, oe_next;
  logic        mreq_n_reg, mreq_n_next, iorq_n_reg, iorq_n_next;
  logic        rd_n_reg, rd_n_next, wr_n_reg, wr_n_next;
  logic        sltsl_n_reg, sltsl_n_next, m1_n_reg, m1_n_next;
  logic        cs1_n_reg, cs1_n_next, cs2_n_reg, cs2_n_next, cs12_n_reg, cs12_n_next;
  logic        bus_phase, mem_rd;

  assign forced_load  = io_reg ? IO_FORCED : (m1_reg ? M1_FORCED : 8'd0);
  assign wait_cnt_inc = (wait_cnt_reg == 8'hFF) ? 8'hFF : wait_cnt_reg + 8'd1;
  assign mem_rd       = !io_reg && !write_reg;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      io_reg        <= 1'b0;
      m1_reg        <= 1'b0;
      sltsl_reg     <= 1'b0;
      addr_reg      <= 16'h0000;
      dout_reg      <= 8'h00;
      rdata_reg     <= 8'h00;
      forced_reg    <= 8'd0;
      wait_cnt_reg  <= 8'd0;
      err_reg       <= 1'b0;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      oe_reg        <= 1'b0;
      mreq_n_reg    <= 1'b1;
      iorq_n_reg    <= 1'b1;
      rd_n_reg      <= 1'b1;
      wr_n_reg      <= 1'b1;
      sltsl_n_reg   <= 1'b1;
      m1_n_reg      <= 1'b1;
      cs1_n_reg     <= 1'b1;
      cs2_n_reg     <= 1'b1;
      cs12_n_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      forced_reg    <= forced_next;
      wait_cnt_reg  <= wait_cnt_next;
      err_reg       <= err_next;
      ready_reg     <= ready_next;
      rsp_valid_reg <= rsp_valid_next;
      oe_reg        <= oe_next;
      mreq_n_reg    <= mreq_n_next;
      iorq_n_reg    <= iorq_n_next;
      rd_n_reg      <= rd_n_next;
      wr_n_reg      <= wr_n_next;
      sltsl_n_reg   <= sltsl_n_next;
      m1_n_reg      <= m1_n_next;
      cs1_n_reg     <= cs1_n_next;
      cs2_n_reg     <= cs2_n_next;
      cs12_n_reg    <= cs12_n_next;
      if (state_reg == IDLE && bus.REQ_VALID) begin
        write_reg <= bus.REQ_WRITE;
        io_reg    <= bus.REQ_IO;
        // Opcode fetch only has meaning for memory reads.
        m1_reg    <= bus.REQ_M1 && !bus.REQ_WRITE && !bus.REQ_IO;
        sltsl_reg <= bus.REQ_SLTSL;
        addr_reg  <= bus.REQ_ADDR;
        if (bus.REQ_WRITE) dout_reg <= bus.REQ_WDATA;
      end
      if (state_reg == T3 && bus.CLK_EN && !write_reg) rdata_reg <= bus.DIN;
    end
  end

  always_comb begin
    state_next    = state_reg;
    forced_next   = forced_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout       = 1'b0;
    case (state_reg)
      IDLE: if (bus.REQ_VALID) state_next = ARM;
      ARM:  if (bus.CLK_EN) state_next = T1;
      T1:   if (bus.CLK_EN) state_next = T2;
      T2: if (bus.CLK_EN) begin
        forced_next   = forced_load;
        wait_cnt_next = 8'd0;
        state_next    = (forced_load != 8'd0 || !bus.WAIT_n) ? TW : T3;
      end
      TW: if (bus.CLK_EN) begin
        // The CLK_EN that consumes the last forced wait also samples WAIT_n.
        if (forced_reg > 8'd1) begin
          forced_next = forced_reg - 8'd1;
        end else begin
          forced_next = 8'd0;
          if (bus.WAIT_n) begin
            state_next = T3;
          end else begin
            wait_cnt_next = wait_cnt_inc;
            if (wait_cnt_inc >= TMO_LIMIT) begin
              timeout    = 1'b1;
              state_next = DONE;
            end
          end
        end
      end
      T3:   if (bus.CLK_EN) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_phase      = (state_next == T2) || (state_next == TW) || (state_next == T3);
    ready_next     = (state_next == IDLE);
    rsp_valid_next = (state_next == DONE);
    err_next       = (state_next == DONE) ? timeout : err_reg;
    mreq_n_next    = !(bus_phase && !io_reg);
    iorq_n_next    = !(bus_phase && io_reg);
    rd_n_next      = !(bus_phase && !write_reg);
    wr_n_next      = !(bus_phase && write_reg);
    sltsl_n_next   = !(bus_phase && !io_reg && sltsl_reg);
    cs1_n_next     = !(bus_phase && mem_rd && addr_reg[15:14] == 2'b01);
    cs2_n_next     = !(bus_phase && mem_rd && addr_reg[15:14] == 2'b10);
    cs12_n_next    = !(bus_phase && mem_rd && addr_reg[15:14] inside {2'b01, 2'b10});
    m1_n_next      = !(m1_reg && (state_next == T1 || state_next == T2));
    oe_next        = write_reg && (bus_phase || state_next == T1);
  end

  assign bus.REQ_READY = ready_reg;
  assign bus.RSP_VALID = rsp_valid_reg;
  assign bus.RSP_RDATA = rdata_reg;
  assign bus.RSP_ERR   = err_reg;
  assign bus.ADDR      = addr_reg;
  assign bus.DOUT      = dout_reg;
  assign bus.DOUT_OE   = oe_reg;
  assign bus.MERQ_n    = mreq_n_reg;
  assign bus.IORQ_n    = iorq_n_reg;
  assign bus.RD_n      = rd_n_reg;
  assign bus.WR_n      = wr_n_reg;
  assign bus.SLTSL_n   = sltsl_n_reg;
  assign bus.CS1_n     = cs1_n_reg;
  assign bus.CS2_n     = cs2_n_reg;
  assign bus.CS12_n    = cs12_n_reg;
  assign bus.M1_n      = m1_n_reg;
  assign bus.RFSH_n    = 1'b1;
endmodule

// File: tb/tb_msx_bus_initiator.sv
// Directed vector bench for msx_bus_initiator: counts strobe-low T-states per cycle and
// checks them, the response and the bus invariants against hand-computed tables.
module tb_msx_bus_initiator;
  localparam int TMO = 6;

  typedef struct {
    bit          wr, io, m1, sltsl;
    logic [15:0] addr;
    logic [7:0]  wdata, din;
    int          wl;
    logic [7:0]  exp_rdata;
    bit          exp_err;
    int          tst, mreq, iorq, rd, wrs, sl, cs1, cs2, cs12, m1n, oe;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;
  vec_t v[9];
  vec_t v_rec;

  msx_bus_initiator_if bus();

  msx_bus_initiator #(.IO_AUTO_WAIT(1), .M1_EXTRA_WAIT(1), .WAIT_TIMEOUT(TMO)) dut (
    .CLK(clk), .RESET_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // One CLK_EN pulse every third CLK.
  initial begin
    int ph = 0;
    bus.CLK_EN = 1'b0;
    forever begin
      @(posedge clk); #1;
      ph = (ph == 2) ? 0 : ph + 1;
      bus.CLK_EN = (ph == 2);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int n_t = 0, n_mreq = 0, n_iorq = 0, n_rd = 0, n_wr = 0, n_sl = 0;
    int n_cs1 = 0, n_cs2 = 0, n_cs12 = 0, n_m1 = 0, n_oe = 0;
    int k = 0, cyc = 0, viol = 0;
    bit done = 0, released = 0;
    logic [7:0] rdata = 8'h00;
    logic err = 1'b0;
    @(negedge clk);
    bus.REQ_WRITE = t.wr;  bus.REQ_IO = t.io;  bus.REQ_M1 = t.m1;  bus.REQ_SLTSL = t.sltsl;
    bus.REQ_ADDR = t.addr; bus.REQ_WDATA = t.wdata; bus.DIN = t.din;
    bus.REQ_VALID = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.REQ_VALID && !bus.REQ_READY) bus.REQ_VALID = 1'b0;
      if (bus.RSP_VALID) begin
        rdata = bus.RSP_RDATA;
        err = bus.RSP_ERR;
        released = bus.MERQ_n && bus.IORQ_n && bus.RD_n && bus.WR_n && bus.SLTSL_n &&
                   bus.CS1_n && bus.CS2_n && bus.CS12_n && bus.M1_n && !bus.DOUT_OE;
        done = 1;
      end else begin
        if (!bus.RD_n && !bus.WR_n) viol++;
        if (bus.DOUT_OE && !bus.RD_n) viol++;
        if (!bus.RFSH_n) viol++;
        if (bus.DOUT_OE && bus.DOUT !== t.wdata) viol++;
        if ((!bus.RD_n || !bus.WR_n || !bus.M1_n) && bus.ADDR !== t.addr) viol++;
        if (!bus.REQ_READY && bus.CLK_EN) begin
          n_t++;
          if (!bus.MERQ_n)  n_mreq++;
          if (!bus.IORQ_n)  n_iorq++;
          if (!bus.RD_n)    n_rd++;
          if (!bus.WR_n)    n_wr++;
          if (!bus.SLTSL_n) n_sl++;
          if (!bus.CS1_n)   n_cs1++;
          if (!bus.CS2_n)   n_cs2++;
          if (!bus.CS12_n)  n_cs12++;
          if (!bus.M1_n)    n_m1++;
          if (bus.DOUT_OE)  n_oe++;
        end
        // WAIT_n is glitched low between CLK_EN pulses; only its CLK_EN value matters.
        if (!bus.RD_n || !bus.WR_n) begin
          if (bus.CLK_EN) begin
            bus.WAIT_n = (k < t.wl) ? 1'b0 : 1'b1;
            k++;
          end else begin
            bus.WAIT_n = 1'b0;
          end
        end else begin
          bus.WAIT_n = 1'b1;
        end
      end
    end
    bus.WAIT_n = 1'b1;
    bus.REQ_VALID = 1'b0;
    chk("rsp_seen", 32'(done), 32'd1);
    chk("rdata", 32'(rdata), 32'(t.exp_rdata));
    chk("err", 32'(err), 32'(t.exp_err));
    chk("released", 32'(released), 32'd1);
    chk("tstates", n_t, t.tst);
    chk("merq_low", n_mreq, t.mreq);
    chk("iorq_low", n_iorq, t.iorq);
    chk("rd_low", n_rd, t.rd);
    chk("wr_low", n_wr, t.wrs);
    chk("sltsl_low", n_sl, t.sl);
    chk("cs1_low", n_cs1, t.cs1);
    chk("cs2_low", n_cs2, t.cs2);
    chk("cs12_low", n_cs12, t.cs12);
    chk("m1_low", n_m1, t.m1n);
    chk("oe_high", n_oe, t.oe);
    chk("bus_rules", viol, 0);
    @(negedge clk);
    chk("rsp_pulse_1clk", 32'(bus.RSP_VALID), 32'd0);
    chk("ready_after_done", 32'(bus.REQ_READY), 32'd1);
    $display("txn %0d: wr=%0b io=%0b m1=%0b addr=%h rdata=%h err=%0b tstates=%0d rd=%0d wr=%0d",
             txn, t.wr, t.io, t.m1, t.addr, rdata, err, n_t, n_rd, n_wr);
    txn++;
  endtask

  initial begin
    int k = 0, cyc = 0;
    bus.REQ_VALID = 1'b0; bus.REQ_WRITE = 1'b0; bus.REQ_IO = 1'b0; bus.REQ_M1 = 1'b0;
    bus.REQ_SLTSL = 1'b0; bus.REQ_ADDR = 16'h0000; bus.REQ_WDATA = 8'h00;
    bus.DIN = 8'h00; bus.WAIT_n = 1'b1;

    //        wr    io    m1    slt   addr      wdata  din    wl rdata  err tst mrq ioq rd wr sl cs1 cs2 c12 m1 oe
    v[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4123, 8'h00, 8'hA5, 0, 8'hA5, 1'b0, 4, 2, 0, 2, 0, 2, 2, 0, 2, 0, 0};
    v[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h8000, 8'h3C, 8'h00, 0, 8'hA5, 1'b0, 4, 2, 0, 0, 2, 2, 0, 0, 0, 0, 3};
    v[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0098, 8'h00, 8'h11, 0, 8'h11, 1'b0, 5, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0};
    v[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0099, 8'h5A, 8'h00, 0, 8'h11, 1'b0, 5, 0, 3, 0, 3, 0, 0, 0, 0, 0, 4};
    v[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h8100, 8'h00, 8'hC3, 0, 8'hC3, 1'b0, 5, 3, 0, 3, 0, 0, 0, 3, 3, 2, 0};
    v[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hC000, 8'h00, 8'h7E, 5, 8'h7E, 1'b0, 9, 7, 0, 7, 0, 7, 0, 0, 0, 0, 0};
    v[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h7FFF, 8'h00, 8'h81, 6, 8'h81, 1'b0, 10, 8, 0, 8, 0, 0, 8, 0, 8, 0, 0};
    v[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 8'h99, 7, 8'h81, 1'b1, 9, 7, 0, 7, 0, 7, 7, 0, 7, 0, 0};
    v[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h4000, 8'h96, 8'h00, 0, 8'h81, 1'b0, 4, 2, 0, 0, 2, 0, 0, 0, 0, 0, 3};
    v_rec = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h4123, 8'h00, 8'h5A, 0, 8'h5A, 1'b0, 4, 2, 0, 2, 0, 2, 2, 0, 2, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.REQ_READY), 32'd1);
    chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_rsp_err", 32'(bus.RSP_ERR), 32'd0);
    chk("rst_rdata", 32'(bus.RSP_RDATA), 32'd0);
    chk("rst_addr", 32'(bus.ADDR), 32'd0);
    chk("rst_dout", 32'(bus.DOUT), 32'd0);
    chk("rst_oe", 32'(bus.DOUT_OE), 32'd0);
    chk("rst_strobes", 32'({bus.MERQ_n, bus.IORQ_n, bus.RD_n, bus.WR_n, bus.SLTSL_n,
                            bus.CS1_n, bus.CS2_n, bus.CS12_n, bus.M1_n, bus.RFSH_n}), 32'h3FF);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(v[i]);

    // Reset in the middle of a WAIT-stretched memory write.
    @(negedge clk);
    bus.REQ_WRITE = 1'b1; bus.REQ_IO = 1'b0; bus.REQ_M1 = 1'b0; bus.REQ_SLTSL = 1'b1;
    bus.REQ_ADDR = 16'h4000; bus.REQ_WDATA = 8'hE7; bus.REQ_VALID = 1'b1;
    while (k < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.REQ_VALID && !bus.REQ_READY) bus.REQ_VALID = 1'b0;
      if (!bus.WR_n && bus.CLK_EN) k++;
      bus.WAIT_n = 1'b0;
    end
    chk("rst_mid_reached_tw", k, 3);
    chk("rst_mid_wr_before", 32'(bus.WR_n), 32'd0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wr_n", 32'(bus.WR_n), 32'd1);
    chk("rst_mid_merq_n", 32'(bus.MERQ_n), 32'd1);
    chk("rst_mid_sltsl_n", 32'(bus.SLTSL_n), 32'd1);
    chk("rst_mid_oe", 32'(bus.DOUT_OE), 32'd0);
    chk("rst_mid_rsp", 32'(bus.RSP_VALID), 32'd0);
    repeat (2) @(negedge clk);
    bus.WAIT_n = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 32'(bus.REQ_READY), 32'd1);
    chk("rst_rel_rsp", 32'(bus.RSP_VALID), 32'd0);
    chk("rst_rel_rdata", 32'(bus.RSP_RDATA), 32'd0);
    $display("txn %0d: reset during TW of write, wr_n=%0b oe=%0b ready=%0b",
             txn, bus.WR_n, bus.DOUT_OE, bus.REQ_READY);
    txn++;

    run_vec(v_rec);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
